// File: rtl/fwd_interlock.sv
// Forwarding and load-use interlock beside ID: tracks DEPTH in-flight writers,
// picks the youngest producer per source operand, stalls on unready results.

module fwd_interlock_op #(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int SELW  = 2
) (
  input  logic [RW-1:0]             i_src,
  input  logic                      i_use,
  input  logic [DEPTH-1:0]          i_live,
  input  logic [DEPTH-1:0]          i_rdy,
  input  logic [DEPTH-1:0][RW-1:0]  i_rd,
  output logic                      o_stall,
  output logic [SELW-1:0]           o_sel
);

  logic            w_hit;
  logic            w_rdy;
  logic [SELW-1:0] w_sel;

  // Scan oldest to youngest so the lowest matching position overrides.
  always_comb begin
    w_hit = 1'b0;
    w_rdy = 1'b0;
    w_sel = '0;
    for (int j = DEPTH-1; j >= 0; j--) begin
      if (i_use && (i_src != '0) && i_live[j] && (i_rd[j] == i_src)) begin
        w_hit = 1'b1;
        w_rdy = i_rdy[j];
        w_sel = SELW'(j + 1);
      end
    end
  end

  assign o_stall = w_hit & ~w_rdy;
  assign o_sel   = (w_hit && w_rdy) ? w_sel : '0;

endmodule

module fwd_interlock #(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int LATW  = 2,
  parameter int CNTW  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          id_valid_i,
  input  logic                          id_wr_i,
  input  logic [RW-1:0]                 id_rd_i,
  input  logic [LATW-1:0]               id_lat_i,
  input  logic [NSRC*RW-1:0]            src_i,
  input  logic [NSRC-1:0]               src_use_i,
  input  logic                          hold_i,
  input  logic                          flush_i,
  output logic [NSRC*$clog2(DEPTH+1)-1:0] fwd_sel_o,
  output logic                          stall_o,
  output logic [CNTW-1:0]               stall_cnt_o
);

  localparam int SELW   = $clog2(DEPTH+1);
  localparam int LATMAX = DEPTH - 1;

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][RW-1:0]     r_rd;
  logic [DEPTH-1:0][LATW-1:0]   r_cnt;
  logic [CNTW-1:0]              r_stall_cnt;

  logic [DEPTH-1:0]             w_live;
  logic [DEPTH-1:0]             w_rdy;
  logic [NSRC-1:0]              w_op_stall;
  logic [NSRC-1:0][SELW-1:0]    w_op_sel;
  logic                         w_stall;
  logic [LATW-1:0]              w_lat;
  logic [DEPTH-1:0]             w_v_nxt;
  logic [DEPTH-1:0][RW-1:0]     w_rd_nxt;
  logic [DEPTH-1:0][LATW-1:0]   w_cnt_nxt;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_live[j] = r_v[j] & (r_rd[j] != '0);
      w_rdy[j]  = (r_cnt[j] == '0);
    end
  end

  genvar k;
  generate
    for (k = 0; k < NSRC; k++) begin : g_op
      fwd_interlock_op #(
        .RW    (RW),
        .DEPTH (DEPTH),
        .SELW  (SELW)
      ) u_op (
        .i_src   (src_i[k*RW +: RW]),
        .i_use   (src_use_i[k]),
        .i_live  (w_live),
        .i_rdy   (w_rdy),
        .i_rd    (r_rd),
        .o_stall (w_op_stall[k]),
        .o_sel   (w_op_sel[k])
      );
    end
  endgenerate

  assign w_stall     = id_valid_i & (|w_op_stall);
  assign stall_o     = w_stall;
  assign fwd_sel_o   = w_stall ? '0 : w_op_sel;
  assign stall_cnt_o = r_stall_cnt;

  // A latency past the last tracked slot would never mature; cap it there.
  always_comb begin
    w_lat = id_lat_i;
    if (int'(id_lat_i) > LATMAX) w_lat = LATW'(LATMAX);
  end

  always_comb begin
    w_v_nxt   = '0;
    w_rd_nxt  = '0;
    w_cnt_nxt = '0;
    for (int j = 1; j < DEPTH; j++) begin
      w_v_nxt[j]   = r_v[j-1];
      w_rd_nxt[j]  = r_rd[j-1];
      w_cnt_nxt[j] = (r_cnt[j-1] == '0) ? '0 : r_cnt[j-1] - 1'b1;
    end
    if (!w_stall && !flush_i) begin
      w_v_nxt[0]   = id_valid_i & id_wr_i;
      w_rd_nxt[0]  = id_rd_i;
      w_cnt_nxt[0] = w_lat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v         <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      r_v   <= w_v_nxt;
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
